// File: rtl/snn_param_pkg.sv
// Shared constants and types for the neuron-parameter load path.
package snn_param_pkg;

  localparam int unsigned PARAM_DSIZE  = 368;
  localparam int unsigned PARAM_BUS_W  = 32;
  localparam int unsigned PARAM_NWORDS = (PARAM_DSIZE + PARAM_BUS_W - 1) / PARAM_BUS_W;
  localparam int unsigned FRAME_CNT_W  = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } loader_state_e;

endpackage

// File: rtl/snn_param_word_assembler.sv
// Collects BUS_W-bit words into one DSIZE-bit frame: word index counter, word placement
// and framing check (in_last must coincide exactly with the final word).
module snn_param_word_assembler
  import snn_param_pkg::*;
#(
  parameter int unsigned DSIZE = PARAM_DSIZE,
  parameter int unsigned BUS_W = PARAM_BUS_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [BUS_W-1:0] i_data,
  input  logic             i_last,
  output logic [DSIZE-1:0] o_frame,
  output logic             o_active,
  output logic             o_done,
  output logic             o_err
);

  localparam int unsigned NWORDS = (DSIZE + BUS_W - 1) / BUS_W;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_d;
  logic [DSIZE-1:0]  r_frame;
  logic [DSIZE-1:0]  w_frame_d;
  logic [NWORDS-1:0] w_wsel;
  logic              w_at_end;

  assign w_at_end = (r_idx == IDX_W'(NWORDS - 1));

  always_comb begin
    w_wsel = '0;
    for (int k = 0; k < NWORDS; k++) begin
      w_wsel[k] = i_we && (r_idx == IDX_W'(k));
    end
  end

  // Walk frame bits rather than words so the truncated top word never indexes past DSIZE.
  always_comb begin
    w_frame_d = r_frame;
    for (int i = 0; i < DSIZE; i++) begin
      if (w_wsel[i / BUS_W]) begin
        w_frame_d[i] = i_data[i % BUS_W];
      end
    end
  end

  always_comb begin
    w_idx_d = r_idx;
    o_done  = 1'b0;
    o_err   = 1'b0;
    if (i_we) begin
      if (i_last && w_at_end) begin
        o_done  = 1'b1;
        w_idx_d = '0;
      end else if (!i_last && !w_at_end) begin
        w_idx_d = r_idx + 1'b1;
      end else begin
        o_err   = 1'b1;
        w_idx_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx   <= '0;
      r_frame <= '0;
    end else begin
      r_idx   <= w_idx_d;
      r_frame <= w_frame_d;
    end
  end

  assign o_frame  = r_frame;
  assign o_active = (r_idx != '0);

endmodule

// File: rtl/snn_param_loader.sv
// Sys-domain producer for the parameter load FIFO: assembles bus words into frames and pushes
// each with one winc pulse. SNN_PARAM_LOADER_DBUF_EN adds a second assembly buffer.
module snn_param_loader
  import snn_param_pkg::*;
#(
  parameter int unsigned DSIZE = PARAM_DSIZE,
  parameter int unsigned BUS_W = PARAM_BUS_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [BUS_W-1:0]       in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   param_winc,
  output logic [DSIZE-1:0]       param_wdata,
  input  logic                   param_wfull,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   frame_error,
  input  logic                   err_clear,
  output logic                   busy
);

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_winc;
  logic                   w_done_any;
  logic                   w_err_any;
  logic                   w_busy;
  logic [DSIZE-1:0]       w_wdata;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_frame_err;

  assign w_accept = in_valid & w_ready;

`ifdef SNN_PARAM_LOADER_DBUF_EN
  logic [1:0]       w_we;
  logic [1:0]       w_done;
  logic [1:0]       w_err;
  logic [1:0]       w_active;
  logic [DSIZE-1:0] w_frame_0;
  logic [DSIZE-1:0] w_frame_1;
  logic [1:0]       r_full;
  logic [1:0]       w_full_d;
  logic             r_wr_sel;
  logic             w_wr_sel_d;
  logic             r_rd_sel;
  logic             w_rd_sel_d;
  loader_state_e    w_state;

  assign w_we[0] = w_accept & ~r_wr_sel;
  assign w_we[1] = w_accept & r_wr_sel;

  snn_param_word_assembler #(
    .DSIZE (DSIZE),
    .BUS_W (BUS_W)
  ) u_asm_0 (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_we     (w_we[0]),
    .i_data   (in_data),
    .i_last   (in_last),
    .o_frame  (w_frame_0),
    .o_active (w_active[0]),
    .o_done   (w_done[0]),
    .o_err    (w_err[0])
  );

  snn_param_word_assembler #(
    .DSIZE (DSIZE),
    .BUS_W (BUS_W)
  ) u_asm_1 (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_we     (w_we[1]),
    .i_data   (in_data),
    .i_last   (in_last),
    .o_frame  (w_frame_1),
    .o_active (w_active[1]),
    .o_done   (w_done[1]),
    .o_err    (w_err[1])
  );

  // The read pointer always names the oldest complete frame, so SEND means "that one is full".
  assign w_state    = r_full[r_rd_sel] ? SEND : COLLECT;
  assign w_ready    = ~r_full[r_wr_sel];
  assign w_winc     = (w_state == SEND) & ~param_wfull & ~reset;
  assign w_done_any = |w_done;
  assign w_err_any  = |w_err;
  assign w_busy     = (|w_active) | (w_state == SEND);
  assign w_wdata    = r_rd_sel ? w_frame_1 : w_frame_0;

  always_comb begin
    w_full_d   = r_full;
    w_wr_sel_d = r_wr_sel;
    w_rd_sel_d = r_rd_sel;
    if (w_winc) begin
      w_full_d[r_rd_sel] = 1'b0;
      w_rd_sel_d         = ~r_rd_sel;
    end
    if (w_done_any) begin
      w_full_d[r_wr_sel] = 1'b1;
      w_wr_sel_d         = ~r_wr_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      r_full   <= w_full_d;
      r_wr_sel <= w_wr_sel_d;
      r_rd_sel <= w_rd_sel_d;
    end
  end
`else
  logic          w_active;
  logic          w_done;
  logic          w_err;
  loader_state_e r_state;
  loader_state_e w_state_d;

  snn_param_word_assembler #(
    .DSIZE (DSIZE),
    .BUS_W (BUS_W)
  ) u_asm (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_we     (w_accept),
    .i_data   (in_data),
    .i_last   (in_last),
    .o_frame  (w_wdata),
    .o_active (w_active),
    .o_done   (w_done),
    .o_err    (w_err)
  );

  assign w_ready    = (r_state == COLLECT);
  assign w_winc     = (r_state == SEND) & ~param_wfull & ~reset;
  assign w_done_any = w_done;
  assign w_err_any  = w_err;
  assign w_busy     = w_active | (r_state == SEND);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      COLLECT: if (w_done_any) w_state_d = SEND;
      SEND:    if (w_winc)     w_state_d = COLLECT;
      default: w_state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_d;
    end
  end
`endif

  // A fresh framing error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_winc) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_err_any) begin
        r_frame_err <= 1'b1;
      end else if (err_clear) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign in_ready    = w_ready;
  assign param_winc  = w_winc;
  assign param_wdata = w_wdata;
  assign frame_count = r_frame_cnt;
  assign frame_error = r_frame_err;
  assign busy        = w_busy;

endmodule

// File: tb/tb_snn_param_loader.sv
// Scoreboard bench for snn_param_loader: expected frames are queued at stimulus time and a
// negedge monitor checks every winc against the queue head.
module tb_snn_param_loader;
  import snn_param_pkg::*;

  localparam int DSIZE = PARAM_DSIZE;
  localparam int BUS_W = PARAM_BUS_W;
`ifdef SNN_PARAM_LOADER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef struct packed {
    logic [DSIZE-1:0] data;
    logic [15:0]      cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [BUS_W-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             param_winc;
  logic [DSIZE-1:0] param_wdata;
  logic             param_wfull;
  logic [15:0]      frame_count;
  logic             frame_error;
  logic             err_clear;
  logic             busy;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;

  snn_param_loader dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .param_winc  (param_winc),
    .param_wdata (param_wdata),
    .param_wfull (param_wfull),
    .frame_count (frame_count),
    .frame_error (frame_error),
    .err_clear   (err_clear),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DSIZE-1:0] mk_frame(input logic [31:0] base);
    logic [PARAM_NWORDS*BUS_W-1:0] p;
    p = '0;
    for (int k = 0; k < PARAM_NWORDS; k++) p[k*BUS_W +: BUS_W] = base + 32'(k);
    return p[DSIZE-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (param_winc === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_winc: winc with empty scoreboard (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        if (param_wdata !== e.data || frame_count !== e.cnt) begin
          errors++;
          $display("FAIL winc_frame: got data=0x%0h count=%0d expected data=0x%0h count=%0d",
                   param_wdata, frame_count, e.data, e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready stayed 0 for word 0x%0h", d);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base, input int n, input int last_at,
                            input bit push);
    if (push) begin
      q.push_back('{data: mk_frame(base), cnt: exp_cnt});
      exp_cnt++;
    end
    for (int k = 0; k < n; k++) send_word(base + 32'(k), k == last_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    param_wfull = 1'b0; err_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_winc", 32'(param_winc), 32'd0);
    check("rst_wdata_zero", 32'(param_wdata == '0), 32'd1);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_error", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Basic frame 0..11, winc exactly one cycle after word 11.
    send_frame(32'h0, 12, 11, 1'b1);
    check("t1_winc_latency", 32'(param_winc), 32'd1);
    check("t1_in_ready_send", 32'(in_ready), DBUF ? 32'd1 : 32'd0);
    check("t1_wdata_lo", param_wdata[31:0], 32'h0);
    check("t1_wdata_351_320", param_wdata[351:320], 32'hA);
    check("t1_wdata_top", 32'(param_wdata[367:352]), 32'hB);
    tick();
    check("t1_count", 32'(frame_count), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // Full held for 5 cycles: no winc, frame kept.
    param_wfull = 1'b1;
    send_frame(32'h0, 12, 11, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("t2_no_winc_full", 32'(param_winc), 32'd0);
      check("t2_in_ready_full", 32'(in_ready), DBUF ? 32'd1 : 32'd0);
      tick();
    end
    check("t2_busy_full", 32'(busy), 32'd1);
    param_wfull = 1'b0;
    #1;
    check("t2_winc_release", 32'(param_winc), 32'd1);
    tick();
    check("t2_count", 32'(frame_count), 32'd2);

    // Early in_last on word 4.
    send_frame(32'h100, 5, 4, 1'b0);
    check("t3_error_early", 32'(frame_error), 32'd1);
    check("t3_busy_idx0", 32'(busy), 32'd0);
    send_frame(32'h200, 12, 11, 1'b1);
    tick();
    check("t3_count_after_err", 32'(frame_count), 32'd3);
    check("t3_error_sticky", 32'(frame_error), 32'd1);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("t3_error_cleared", 32'(frame_error), 32'd0);

    // Missing in_last on word 11.
    send_frame(32'h300, 12, -1, 1'b0);
    tick();
    check("t4_error_missing", 32'(frame_error), 32'd1);
    check("t4_count_same", 32'(frame_count), 32'd3);
    check("t4_busy", 32'(busy), 32'd0);
    err_clear = 1'b1;
    send_word(32'h0, 1'b1);
    err_clear = 1'b0;
    check("t4_error_wins", 32'(frame_error), 32'd1);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("t4_error_cleared", 32'(frame_error), 32'd0);

    // Reset mid-frame after word 6.
    send_frame(32'h400, 7, -1, 1'b0);
    check("t5_busy_partial", 32'(busy), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    exp_cnt = '0;
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    check("t5_ready_after_rst", 32'(in_ready), 32'd1);
    check("t5_count_after_rst", 32'(frame_count), 32'd0);
    send_frame(32'h500, 12, 11, 1'b1);
    tick();
    check("t5_count_new", 32'(frame_count), 32'd1);

    // Reset while a frame is pending on wfull: the release in the reset cycle must not push.
    param_wfull = 1'b1;
    send_frame(32'h600, 12, 11, 1'b0);
    check("t6_busy_pending", 32'(busy), 32'd1);
    reset = 1'b1; param_wfull = 1'b0;
    #1;
    check("t6_no_winc_in_reset", 32'(param_winc), 32'd0);
    tick(); reset = 1'b0;
    exp_cnt = '0;
    check("t6_busy_cleared", 32'(busy), 32'd0);
    check("t6_winc_dropped", 32'(param_winc), 32'd0);
    check("t6_count_zero", 32'(frame_count), 32'd0);

`ifdef SNN_PARAM_LOADER_DBUF_EN
    // Two frames buffered behind wfull, then drained in order.
    param_wfull = 1'b1;
    send_frame(32'h700, 12, 11, 1'b1);
    send_frame(32'h800, 12, 11, 1'b1);
    check("t7_ready_both_full", 32'(in_ready), 32'd0);
    check("t7_busy", 32'(busy), 32'd1);
    param_wfull = 1'b0;
    tick(); tick(); tick();
    check("t7_count", 32'(frame_count), 32'd2);
    check("t7_ready_again", 32'(in_ready), 32'd1);
`endif

    tick(); tick(); tick();
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
